// File: rtl/keypad_pkg.sv
// Shared types, key codes and the keypad position-to-code map.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_class_t;

    typedef enum logic {IDLE, PRESSED} state_t;

    // Rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'h0;
            4'hE: code = KEY_HASH;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Column scanner: row synchronizer, column drive and per-frame key classification.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS = 100_000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [3:0]   i_filas,
    output logic [3:0]   o_columnas,
    output logic         o_frame_done,
    output frame_class_t o_frame_class,
    output logic [3:0]   o_frame_code
);

    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

    logic [3:0]    r_meta;
    logic [3:0]    r_sync;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_col;
    logic [3:0]    r_columnas;
    logic [1:0]    r_hits;
    logic [3:0]    r_code;
    logic          r_frame_done;
    frame_class_t  r_frame_class;
    logic [3:0]    r_frame_code;

    logic          w_sample;
    logic [3:0]    w_pressed;
    logic [2:0]    w_col_hits;
    logic [1:0]    w_col_row;
    logic [2:0]    w_total;
    logic [1:0]    w_hits_next;
    logic [3:0]    w_code_next;

    // Two-flop synchronizer for the asynchronous row returns
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_filas;
            r_sync <= r_meta;
        end
    end

    // Column period counter and one-hot-low column drive
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick     <= '0;
            r_col      <= '0;
            r_columnas <= 4'b1110;
        end else if (r_tick == TICK_LAST) begin
            r_tick     <= '0;
            r_col      <= r_col + 2'd1;
            r_columnas <= {r_columnas[2:0], r_columnas[3]};
        end else begin
            r_tick <= r_tick + TW'(1);
        end
    end

    // Count pressed rows in the current column and locate one of them
    always_comb begin
        w_sample    = (r_tick == TICK_LAST);
        w_pressed   = ~r_sync;
        w_col_hits  = {2'b0, w_pressed[0]} + {2'b0, w_pressed[1]}
                    + {2'b0, w_pressed[2]} + {2'b0, w_pressed[3]};
        w_col_row   = 2'd0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (w_pressed[r]) w_col_row = 2'(r);
        end
        w_total     = {1'b0, r_hits} + w_col_hits;
        w_hits_next = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
        w_code_next = (r_hits == 2'd0 && w_col_hits == 3'd1) ? key_code(w_col_row, r_col) : r_code;
    end

    // Accumulate key hits across the four columns and publish the frame result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hits        <= '0;
            r_code        <= '0;
            r_frame_done  <= 1'b0;
            r_frame_class <= NONE;
            r_frame_code  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_sample) begin
                if (r_col == 2'd3) begin
                    r_hits        <= '0;
                    r_code        <= '0;
                    r_frame_done  <= 1'b1;
                    r_frame_code  <= w_code_next;
                    r_frame_class <= (w_hits_next == 2'd0) ? NONE :
                                     (w_hits_next == 2'd1) ? SINGLE : MULTI;
                end else begin
                    r_hits <= w_hits_next;
                    r_code <= w_code_next;
                end
            end
        end
    end

    assign o_columnas    = r_columnas;
    assign o_frame_done  = r_frame_done;
    assign o_frame_class = r_frame_class;
    assign o_frame_code  = r_frame_code;

endmodule

// File: rtl/keypad_entry.sv
// Keypad decimal entry: debounces scan frames, accepts keys and builds an 8-bit operand.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 100_000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [3:0] o_columnas,
    input  logic [3:0] i_filas,
    output logic [3:0] o_tecla,
    output logic       o_tecla_strobe,
    output logic [7:0] o_acumulado,
    output logic [7:0] o_valor,
    output logic       o_valido,
    output logic       o_desborde
);

    localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_FRAMES);

    logic         w_frame_done;
    frame_class_t w_frame_class;
    logic [3:0]   w_frame_code;

    frame_class_t r_prev_class;
    logic [3:0]   r_prev_code;
    logic [7:0]   r_db_cnt;
    state_t       r_state;
    logic [3:0]   r_tecla;
    logic         r_strobe;
    logic [7:0]   r_acc;
    logic [7:0]   r_valor;
    logic         r_valido;
    logic         r_desb;

    logic         w_same;
    logic [7:0]   w_db_next;
    logic         w_stable;
    state_t       w_state_next;
    logic         w_accept;
    logic [11:0]  w_acc_next;

    keypad_scan #(
        .SCAN_TICKS(SCAN_TICKS)
    ) u_scan (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_filas      (i_filas),
        .o_columnas   (o_columnas),
        .o_frame_done (w_frame_done),
        .o_frame_class(w_frame_class),
        .o_frame_code (w_frame_code)
    );

    // Frame-to-frame comparison; SINGLE frames only match when the key code matches too
    always_comb begin
        w_same     = (w_frame_class == r_prev_class) &&
                     (w_frame_class != SINGLE || w_frame_code == r_prev_code);
        w_db_next  = !w_same ? 8'd1 : ((r_db_cnt >= DB_MAX) ? r_db_cnt : r_db_cnt + 8'd1);
        w_stable   = w_frame_done && (w_db_next >= DB_MAX);
        w_acc_next = ({4'b0, r_acc} << 3) + ({4'b0, r_acc} << 1) + {8'b0, w_frame_code};
    end

    // Debounce history and counter, updated once per frame
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev_class <= NONE;
            r_prev_code  <= '0;
            r_db_cnt     <= '0;
        end else if (w_frame_done) begin
            r_prev_class <= w_frame_class;
            r_prev_code  <= w_frame_code;
            r_db_cnt     <= w_db_next;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    // FSM next state: accept on a stable single key, re-arm only after a stable release
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_stable && w_frame_class == SINGLE) begin
                    w_accept     = 1'b1;
                    w_state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (w_stable && w_frame_class == NONE) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Key report and accumulator actions on acceptance
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tecla  <= '0;
            r_strobe <= 1'b0;
            r_acc    <= '0;
            r_valor  <= '0;
            r_valido <= 1'b0;
            r_desb   <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_valido <= 1'b0;
            if (w_accept) begin
                r_tecla  <= w_frame_code;
                r_strobe <= 1'b1;
                if (w_frame_code <= 4'd9) begin
                    if (!r_desb) begin
                        if (w_acc_next <= 12'd255) r_acc  <= w_acc_next[7:0];
                        else                       r_desb <= 1'b1;
                    end
                end else if (w_frame_code == KEY_STAR) begin
                    r_acc  <= '0;
                    r_desb <= 1'b0;
                end else if (w_frame_code == KEY_HASH) begin
                    if (!r_desb) begin
                        r_valor  <= r_acc;
                        r_valido <= 1'b1;
                    end
                    r_acc  <= '0;
                    r_desb <= 1'b0;
                end
            end
        end
    end

    assign o_tecla        = r_tecla;
    assign o_tecla_strobe = r_strobe;
    assign o_acumulado    = r_acc;
    assign o_valor        = r_valor;
    assign o_valido       = r_valido;
    assign o_desborde     = r_desb;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad matrix model, accumulator model and event scoreboard.
module tb_keypad_entry;

    typedef struct packed {
        logic [3:0] tecla;
        logic [7:0] acc;
        logic       desb;
        logic       valido;
        logic [7:0] valor;
        logic       strobe;
    } ev_t;

    localparam int FRAME = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic [3:0] tecla;
    logic       tecla_strobe;
    logic [7:0] acumulado;
    logic [7:0] valor;
    logic       valido;
    logic       desborde;

    logic [15:0] keys;
    logic [7:0]  m_acc;
    logic        m_desb;
    logic [7:0]  m_valor;
    int          checks;
    int          failures;
    ev_t         exp_q[$];
    ev_t         obs_q[$];

    keypad_entry #(
        .SCAN_TICKS(4),
        .DEBOUNCE_FRAMES(2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_columnas    (columnas),
        .i_filas       (filas),
        .o_tecla       (tecla),
        .o_tecla_strobe(tecla_strobe),
        .o_acumulado   (acumulado),
        .o_valor       (valor),
        .o_valido      (valido),
        .o_desborde    (desborde)
    );

    always #5 clk = ~clk;

    // Matrix model: a held key pulls its row low while its column is driven low
    always_comb begin
        filas = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    // Record every cycle carrying a strobe or a commit pulse
    always @(negedge clk) begin
        ev_t o;
        if (rst_n && (tecla_strobe || valido)) begin
            o.tecla = tecla; o.acc = acumulado; o.desb = desborde;
            o.valido = valido; o.valor = valor; o.strobe = tecla_strobe;
            obs_q.push_back(o);
        end
    end

    // Matrix position (row*4+col) of each key code
    function automatic int key_idx(input logic [3:0] code);
        case (code)
            4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
            4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
            4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
            4'hE: return 12; 4'h0: return 13; 4'hF: return 14; default: return 15;
        endcase
    endfunction

    task automatic model_accept(input logic [3:0] code);
        ev_t e;
        logic [11:0] n;
        e.valido = 1'b0;
        if (code <= 4'd9) begin
            n = {4'b0, m_acc} * 12'd10 + {8'b0, code};
            if (!m_desb) begin
                if (n <= 12'd255) m_acc = n[7:0];
                else              m_desb = 1'b1;
            end
        end else if (code == 4'hE) begin
            m_acc = 8'd0; m_desb = 1'b0;
        end else if (code == 4'hF) begin
            if (!m_desb) begin m_valor = m_acc; e.valido = 1'b1; end
            m_acc = 8'd0; m_desb = 1'b0;
        end
        e.tecla = code; e.acc = m_acc; e.desb = m_desb; e.valor = m_valor; e.strobe = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] code);
        model_accept(code);
        keys = 16'd1 << key_idx(code);
        repeat (4*FRAME) @(negedge clk);
        keys = '0;
        repeat (4*FRAME) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; keys = '0;
        m_acc = 8'd0; m_desb = 1'b0; m_valor = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({tecla, tecla_strobe, acumulado, valor, valido, desborde} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {tecla, tecla_strobe, acumulado, valor, valido, desborde});
        end
        checks++;
        if (columnas !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b required=1110", columnas); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (columnas !== 4'b1110) begin failures++; $display("FAIL col_at3 got=%b required=1110", columnas); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (columnas !== 4'b1101) begin failures++; $display("FAIL col_at4 got=%b required=1101", columnas); end
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if (columnas !== 4'b1110) begin failures++; $display("FAIL col_at16 got=%b required=1110", columnas); end
    endtask

    task automatic test_entry;
        ev_t e, o;
        press(4'h1); press(4'h2); press(4'h5); press(4'hF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL entry_missing required=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL entry_event got=%h required=%h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL entry_extra got=%0d required=0", obs_q.size()); obs_q.delete(); end
        checks++;
        if (valor !== 8'h7D) begin failures++; $display("FAIL entry_valor got=%h required=7d", valor); end
    endtask

    task automatic test_overflow;
        ev_t e, o;
        press(4'h2); press(4'h5); press(4'h6); press(4'h1); press(4'hF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL ovf_missing required=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL ovf_event got=%h required=%h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL ovf_extra got=%0d required=0", obs_q.size()); obs_q.delete(); end
        checks++;
        if ({valor, desborde, acumulado} !== {8'h7D, 1'b0, 8'd0}) begin
            failures++; $display("FAIL ovf_final got=%h required=%h", {valor, desborde, acumulado}, {8'h7D, 1'b0, 8'd0});
        end
    endtask

    task automatic test_boundary_255;
        ev_t e, o;
        press(4'h2); press(4'h5); press(4'h5); press(4'hF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL b255_missing required=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL b255_event got=%h required=%h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL b255_extra got=%0d required=0", obs_q.size()); obs_q.delete(); end
        checks++;
        if (valor !== 8'hFF) begin failures++; $display("FAIL b255_valor got=%h required=ff", valor); end
    endtask

    task automatic test_letters_star;
        ev_t e, o;
        press(4'h3); press(4'hA); press(4'hD); press(4'hE);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL keys_missing required=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL keys_event got=%h required=%h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL keys_extra got=%0d required=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_bounce;
        ev_t e, o;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? (16'd1 << key_idx(4'h7)) : 16'd0;
            repeat (FRAME) @(negedge clk);
        end
        model_accept(4'h7);
        keys = 16'd1 << key_idx(4'h7);
        repeat (4*FRAME) @(negedge clk);
        keys = '0;
        repeat (4*FRAME) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL bounce_missing required=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL bounce_event got=%h required=%h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL bounce_extra got=%0d required=0", obs_q.size()); obs_q.delete(); end
        checks++;
        if (acumulado !== 8'd7) begin failures++; $display("FAIL bounce_acc got=%0d required=7", acumulado); end
    endtask

    task automatic test_multi;
        ev_t e, o;
        keys = (16'd1 << key_idx(4'h1)) | (16'd1 << key_idx(4'h4));
        repeat (10*FRAME) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL multi_strobe got=%0d required=0", obs_q.size()); obs_q.delete(); end
        model_accept(4'h1);
        keys = 16'd1 << key_idx(4'h1);
        repeat (4*FRAME) @(negedge clk);
        keys = '0;
        repeat (4*FRAME) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL multi_missing required=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL multi_event got=%h required=%h", o, e); end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin failures++; $display("FAIL multi_extra got=%0d required=0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reset_mid;
        ev_t e, o;
        press(4'hE); press(4'h1); press(4'h2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs_q.size() == 0) begin failures++; $display("FAIL rmid_missing required=%h", e); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin failures++; $display("FAIL rmid_event got=%h required=%h", o, e); end
            end
        end
        checks++;
        if (acumulado !== 8'd12) begin failures++; $display("FAIL rmid_pre_acc got=%0d required=12", acumulado); end
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tecla, tecla_strobe, acumulado, valor, valido, desborde} !== 23'd0) begin
            failures++;
            $display("FAIL rmid_outputs got=%h required=0",
                     {tecla, tecla_strobe, acumulado, valor, valido, desborde});
        end
        checks++;
        if (columnas !== 4'b1110) begin failures++; $display("FAIL rmid_col got=%b required=1110", columnas); end
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 8'd0; m_desb = 1'b0; m_valor = 8'd0;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog got=timeout required=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0; keys = '0;
        checks = 0; failures = 0;
        test_reset;
        test_entry;
        test_overflow;
        test_boundary_255;
        test_letters_star;
        test_bounce;
        test_multi;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
